// File: rtl/interface_spimaster.sv
// SPI mode-0 frame master. Sends one BUFFER_SIZE-bit frame MSB first while
// receiving one. A received frame is published on rx_data only when its
// 32-bit header matches MSGID.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | SSEL high, waiting for start
// S_SETUP | SSEL low, SCK low, first MOSI bit presented, CS_SETUP cycles
// S_SHIFT | BUFFER_SIZE SCK periods, CLK_DIV cycles low then CLK_DIV high
// S_HOLD  | SSEL low, SCK low for CS_HOLD cycles after the last falling edge
// S_GAP   | SSEL high for CS_GAP cycles; done pulses in the last one
module interface_spimaster #(
    parameter int          BUFFER_SIZE = 64,
    parameter logic [31:0] MSGID       = 32'h74697277,
    parameter int          CLK_DIV     = 4,
    parameter int          CS_SETUP    = 2,
    parameter int          CS_HOLD     = 2,
    parameter int          CS_GAP      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BUFFER_SIZE-1:0] tx_data,
    output logic [BUFFER_SIZE-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   msgid_error,
    output logic                   busy,
    output logic                   done,
    output logic                   SPI_SCK,
    output logic                   SPI_SSEL,
    output logic                   SPI_MOSI,
    input  logic                   SPI_MISO
);

    localparam int BW = $clog2(BUFFER_SIZE + 1);
    localparam int CW = 16;
    localparam logic [BW-1:0] LAST_BIT = BW'(BUFFER_SIZE - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [BUFFER_SIZE-1:0] tx_sr_q, tx_sr_d;
    logic [BUFFER_SIZE-1:0] rx_sr_q, rx_sr_d;
    logic [BUFFER_SIZE-1:0] rx_data_q, rx_data_d;
    logic                   sck_q, sck_d;
    logic                   ssel_q, ssel_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   err_q, err_d;
    logic                   cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // Next-state and datapath: one down-counter times every phase of the frame.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        sck_d      = sck_q;
        ssel_d     = ssel_q;
        rx_valid_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tx_sr_d = tx_data;
                    rx_sr_d = '0;
                    bit_d   = '0;
                    ssel_d  = 1'b0;
                    sck_d   = 1'b0;
                    cnt_d   = CW'(CS_SETUP - 1);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    cnt_d   = CW'(CLK_DIV - 1);
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SHIFT: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!sck_q) begin
                    // MISO is captured on the same edge that raises SCK.
                    sck_d   = 1'b1;
                    rx_sr_d = {rx_sr_q[BUFFER_SIZE-2:0], SPI_MISO};
                    cnt_d   = CW'(CLK_DIV - 1);
                end else begin
                    sck_d = 1'b0;
                    if (bit_q == LAST_BIT) begin
                        cnt_d   = CW'(CS_HOLD - 1);
                        state_d = S_HOLD;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_sr_d = {tx_sr_q[BUFFER_SIZE-2:0], 1'b0};
                        cnt_d   = CW'(CLK_DIV - 1);
                    end
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    ssel_d  = 1'b1;
                    tx_sr_d = '0;
                    cnt_d   = CW'(CS_GAP - 1);
                    state_d = S_GAP;
                    if (rx_sr_q[BUFFER_SIZE-1 -: 32] == MSGID) begin
                        rx_data_d  = rx_sr_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ssel_d  = 1'b1;
                sck_d   = 1'b0;
                tx_sr_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset parks the bus idle and discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            sck_q      <= 1'b0;
            ssel_q     <= 1'b1;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            sck_q      <= sck_d;
            ssel_q     <= ssel_d;
            rx_valid_q <= rx_valid_d;
            err_q      <= err_d;
        end
    end

    // MOSI is the top of the transmit shift register, so it is a flop output.
    assign SPI_SCK     = sck_q;
    assign SPI_SSEL    = ssel_q;
    assign SPI_MOSI    = tx_sr_q[BUFFER_SIZE-1];
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign msgid_error = err_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_GAP) && cnt_zero;

endmodule

// File: tb/tb_interface_spimaster.sv
// Directed bench for interface_spimaster with a loopback path and a mode-0
// slave model, plus a continuous bus protocol monitor.
module tb_interface_spimaster;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] tx_data = '0;
    logic [63:0] rx_data;
    logic        rx_valid, msgid_error, busy, done;
    logic        SPI_SCK, SPI_SSEL, SPI_MOSI, SPI_MISO;

    logic        loopback = 1'b1;
    logic [63:0] slave_word = '0;
    bit          chk_en = 1'b0;

    int passed = 0;
    int total  = 0;

    // monitor state (written only by the monitor process)
    int          cyc = 0, rises = 0, spacing_err = 0, proto_err = 0;
    int          busy_cnt = 0, done_cnt = 0, rxv_cnt = 0, err_cnt = 0;
    int          ssel_run = 0, last_gap = 0, last_rise = 0;
    bit          first_rise = 1'b1;
    logic        prev_sck = 1'bx, prev_ssel = 1'bx, prev_mosi = 1'bx;
    logic [6:0]  slv_idx = '0;
    logic [5:0]  sidx;
    logic [63:0] slv_rx = '0;

    // snapshots (written only by the stimulus process)
    int b0, d0, v0, e0, r0;

    interface_spimaster dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .msgid_error(msgid_error),
        .busy(busy), .done(done), .SPI_SCK(SPI_SCK), .SPI_SSEL(SPI_SSEL),
        .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
    );

    always #5 clk = ~clk;

    assign sidx     = 6'(7'd63 - slv_idx);
    assign SPI_MISO = loopback ? SPI_MOSI : ((slv_idx < 7'd64) ? slave_word[sidx] : 1'b0);

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            if (prev_sck === 1'b1 && SPI_SCK === 1'b1 && SPI_MOSI !== prev_mosi) proto_err++;
            if (prev_ssel === 1'b1 && SPI_SSEL === 1'b1 && SPI_SCK !== prev_sck) proto_err++;
        end
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        if (rx_valid === 1'b1) rxv_cnt++;
        if (msgid_error === 1'b1) err_cnt++;
        if (SPI_SSEL === 1'b1) begin
            ssel_run++;
            slv_idx = '0;
            first_rise = 1'b1;
        end else begin
            if (ssel_run > 0) last_gap = ssel_run;
            ssel_run = 0;
            if (prev_sck === 1'b0 && SPI_SCK === 1'b1) begin
                rises++;
                slv_rx = {slv_rx[62:0], SPI_MOSI};
                if (!first_rise && (cyc - last_rise) != 8) spacing_err++;
                first_rise = 1'b0;
                last_rise = cyc;
            end
            if (prev_sck === 1'b1 && SPI_SCK === 1'b0) slv_idx = slv_idx + 7'd1;
        end
        prev_sck  = SPI_SCK;
        prev_ssel = SPI_SSEL;
        prev_mosi = SPI_MOSI;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic snap();
        b0 = busy_cnt; d0 = done_cnt; v0 = rxv_cnt; e0 = err_cnt; r0 = rises;
    endtask

    task automatic pulse_start(input logic [63:0] d);
        @(negedge clk);
        tx_data = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("setup_ssel", 64'(SPI_SSEL), 64'd0);
        check("setup_sck", 64'(SPI_SCK), 64'd0);
        check("setup_mosi", 64'(SPI_MOSI), 64'(d[63]));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < 2000), 64'd1);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_ssel", 64'(SPI_SSEL), 64'd1);
        check("rst_sck", 64'(SPI_SCK), 64'd0);
        check("rst_mosi", 64'(SPI_MOSI), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rxv", 64'(rx_valid), 64'd0);
        check("rst_err", 64'(msgid_error), 64'd0);
        check("rst_rxdata", rx_data, 64'd0);
        chk_en = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // loopback frame with matching header
        loopback = 1'b1;
        snap();
        pulse_start(64'h74697277_DEADBEEF);
        wait_done("lb_timeout");
        repeat (3) @(negedge clk);
        check("lb_rises", 64'(rises - r0), 64'd64);
        check("lb_busy_cycles", 64'(busy_cnt - b0), 64'd520);
        check("lb_rxdata", rx_data, 64'h74697277_DEADBEEF);
        check("lb_rxv", 64'(rxv_cnt - v0), 64'd1);
        check("lb_done", 64'(done_cnt - d0), 64'd1);
        check("lb_err", 64'(err_cnt - e0), 64'd0);
        check("lb_busy_end", 64'(busy), 64'd0);

        // slave with wrong header: error pulse, rx_data untouched
        loopback = 1'b0;
        slave_word = 64'h12345678_00000001;
        snap();
        pulse_start(64'hC0FFEE00_12345678);
        wait_done("mm_timeout");
        repeat (3) @(negedge clk);
        check("mm_err", 64'(err_cnt - e0), 64'd1);
        check("mm_rxv", 64'(rxv_cnt - v0), 64'd0);
        check("mm_rxdata", rx_data, 64'h74697277_DEADBEEF);
        check("mm_done", 64'(done_cnt - d0), 64'd1);
        check("mm_slave_rx", slv_rx, 64'hC0FFEE00_12345678);

        // slave with matching header; a mid-frame start must be ignored
        slave_word = 64'h74697277_CAFEF00D;
        snap();
        pulse_start(64'h5A5A5A5A_01020304);
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("sl_timeout");
        repeat (10) @(negedge clk);
        check("sl_rxdata", rx_data, 64'h74697277_CAFEF00D);
        check("sl_slave_rx", slv_rx, 64'h5A5A5A5A_01020304);
        check("sl_rxv", 64'(rxv_cnt - v0), 64'd1);
        check("sl_done", 64'(done_cnt - d0), 64'd1);
        check("sl_busy_cycles", 64'(busy_cnt - b0), 64'd520);
        check("sl_busy_end", 64'(busy), 64'd0);

        // start held high: two back-to-back frames
        loopback = 1'b1;
        snap();
        @(negedge clk);
        tx_data = 64'h74697277_13579BDF;
        start = 1'b1;
        wait_done("b2b_timeout1");
        @(negedge clk);
        wait_done("b2b_timeout2");
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("b2b_rises", 64'(rises - r0), 64'd128);
        check("b2b_done", 64'(done_cnt - d0), 64'd2);
        check("b2b_rxv", 64'(rxv_cnt - v0), 64'd2);
        check("b2b_gap", 64'(last_gap), 64'd5);
        check("b2b_busy_cycles", 64'(busy_cnt - b0), 64'd1040);
        check("b2b_rxdata", rx_data, 64'h74697277_13579BDF);

        // reset during bit 20 of the shift phase
        snap();
        pulse_start(64'h74697277_0BADF00D);
        begin
            int n = 0;
            while ((rises - r0) < 20 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("rst_mid_timeout", 64'(n < 2000), 64'd1);
        end
        check("rst_mid_sck_pre", 64'(SPI_SCK), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ssel", 64'(SPI_SSEL), 64'd1);
        check("rst_mid_sck", 64'(SPI_SCK), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_mosi", 64'(SPI_MOSI), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        check("rst_mid_done", 64'(done_cnt - d0), 64'd0);
        check("rst_mid_rxv", 64'(rxv_cnt - v0), 64'd0);
        check("rst_mid_err", 64'(err_cnt - e0), 64'd0);
        check("rst_mid_rxdata", rx_data, 64'd0);

        // first frame after reset completes normally
        snap();
        pulse_start(64'h74697277_600DCAFE);
        wait_done("post_rst_timeout");
        repeat (3) @(negedge clk);
        check("post_rst_rxdata", rx_data, 64'h74697277_600DCAFE);
        check("post_rst_rxv", 64'(rxv_cnt - v0), 64'd1);
        check("post_rst_rises", 64'(rises - r0), 64'd64);

        check("protocol", 64'(proto_err), 64'd0);
        check("sck_spacing", 64'(spacing_err), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/interface_spimaster.md
INTERFACE_SPIMASTER -- requirements
Module: interface_spimaster

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 64, frame length in bits (min 33).
REQ-002 SHALL have parameter MSGID, default 32'h74697277, required header in rx_data[BUFFER_SIZE-1:BUFFER_SIZE-32].
REQ-003 SHALL have parameter CLK_DIV, default 4, clk cycles per SCK half-period (min 4).
REQ-004 SHALL have parameters CS_SETUP, CS_HOLD and CS_GAP, default 2, 2 and 4, in clk cycles (min 1 each).
REQ-005 SHALL have clk, input, 1, the single system clock.
REQ-006 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have start, input, 1, one-cycle frame request.
REQ-008 SHALL have tx_data, input, BUFFER_SIZE, frame to send, MSB first.
REQ-009 SHALL have rx_data, output, BUFFER_SIZE, last accepted received frame.
REQ-010 SHALL have rx_valid, output, 1, one-cycle pulse on rx_data update.
REQ-011 SHALL have msgid_error, output, 1, one-cycle pulse on header mismatch.
REQ-012 SHALL have busy and done, outputs, 1 each: frame in progress, and one-cycle frame-complete pulse.
REQ-013 SHALL have SPI_SCK, SPI_SSEL and SPI_MOSI as outputs and SPI_MISO as input, 1 bit each, SPI mode 0, SSEL active low.

Function
REQ-014 SHALL use the FSM IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-015 In IDLE, start=1 SHALL latch tx_data into the shift register and enter SETUP on the next edge; start is ignored in every other state.
REQ-016 SETUP SHALL drive SPI_SSEL=0, SPI_SCK=0 and SPI_MOSI=tx_data[BUFFER_SIZE-1] for CS_SETUP cycles.
REQ-017 SHIFT SHALL generate exactly BUFFER_SIZE SCK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
REQ-018 SHALL sample SPI_MISO into the receive shift register LSB in the cycle SCK is driven 0->1.
REQ-019 SHALL advance SPI_MOSI to the next bit on each SCK 1->0 transition except after the last bit.
REQ-020 SHALL keep SPI_MOSI stable through each entire high phase.
REQ-021 The SCK period counter and the bit counter SHALL be internal; the bit counter SHALL be ceil(log2(BUFFER_SIZE+1)) bits wide.
REQ-022 HOLD SHALL keep SPI_SSEL=0 and SPI_SCK=0 for CS_HOLD cycles after the final falling edge.
REQ-023 GAP SHALL drive SPI_SSEL=1 for CS_GAP cycles.
REQ-024 On the HOLD->GAP transition, if received bits [BUFFER_SIZE-1:BUFFER_SIZE-32] equal MSGID, rx_data SHALL load the received frame and rx_valid SHALL pulse.
REQ-025 On the HOLD->GAP transition with a header mismatch, rx_data SHALL hold its value and msgid_error SHALL pulse.
REQ-026 done SHALL pulse in the GAP->IDLE transition cycle.
REQ-027 busy SHALL be 1 from the cycle after start is accepted through the cycle done is high.
REQ-028 A start arriving in the same cycle as done SHALL be ignored; start accepted in IDLE on the following cycle SHALL proceed normally (back-to-back frames).
REQ-029 SPI_SCK, SPI_SSEL and SPI_MOSI SHALL be driven directly from flops (glitch-free).

Reset
REQ-030 rst_n=0 SHALL immediately (asynchronously) force the FSM to IDLE.
REQ-031 rst_n=0 SHALL immediately force SPI_SSEL=1, SPI_SCK=0, SPI_MOSI=0, busy=0, done=0, rx_valid=0, msgid_error=0, rx_data=0, and clear all counters.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no rx_valid, msgid_error or done pulse.
REQ-033 After reset release, the first start SHALL produce a complete frame.

Verification (defaults: BUFFER_SIZE=64, CLK_DIV=4, CS_SETUP=2, CS_HOLD=2, CS_GAP=4)
REQ-034 Loopback (MISO tied to MOSI), tx_data=64'h74697277_DEADBEEF, start pulse -> 64 SCK rising edges, each 8 clk apart; busy high 520 cycles; rx_data=64'h74697277_DEADBEEF; rx_valid pulses once; done pulses once.
REQ-035 Slave model returning 64'h12345678_00000001 -> msgid_error pulses once; rx_data unchanged; done pulses.
REQ-036 start held high continuously -> consecutive frames, each separated by SSEL high for CS_GAP cycles plus 1 IDLE cycle; SCK count per frame exactly 64.
REQ-037 rst_n=0 at bit 20 of SHIFT -> same-cycle SPI_SSEL=1 and SPI_SCK=0; no done or rx_valid pulse; next frame correct.
REQ-038 Protocol checker throughout all scenarios -> MOSI never changes while SCK=1; SCK never toggles while SSEL=1.
REQ-039 Connected to the existing SPI slave interface with matching MSGID -> slave rx_data equals tx_data and master rx_data equals the slave's tx_data.
